// File: rtl/adv7513_cfg_sequencer.sv
// ADV7513 configuration sequencer: power-up wait, common init table, then mode registers through the I2C master.
// Optional feature: define ADV_HPD_REINIT_EN to rerun the full table on a synchronised hpd rising edge.
module adv7513_cfg_sequencer #(
  parameter int         POWERUP_DELAY = 200000,
  parameter int         MAX_RETRY     = 3,
  parameter logic [7:0] DEV_ADDR      = 8'h72
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] mode_code,
  input  logic       mode_valid,
  input  logic       hpd,
  output logic       i2c_req,
  output logic [7:0] i2c_dev,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_ack,
  input  logic       i2c_err,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_error
);
  localparam int CW = (POWERUP_DELAY > 1) ? $clog2(POWERUP_DELAY) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] PD_LAST   = CW'(POWERUP_DELAY - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_REQ, S_WAIT, S_NEXT, S_FAIL} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [RW-1:0] r_retry;
  logic [3:0]    r_cur_mode;
  logic [3:0]    r_snap;
  logic          r_mode_pending;
  logic          r_reinit_pending;
  logic          r_req;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic          w_mode_ok;
  logic          w_hpd_rise;

  // Indices 0-5 are the common table, 6-7 the mode registers.
  function automatic logic [15:0] f_entry(input logic [2:0] idx, input logic [3:0] mode);
    logic [7:0] vic;
    case (mode[1:0])
      2'd0:    vic = 8'h10;
      2'd1:    vic = 8'h00;
      2'd2:    vic = 8'h03;
      default: vic = 8'h01;
    endcase
    case (idx)
      3'd0:    f_entry = 16'h4110;
      3'd1:    f_entry = 16'h9803;
      3'd2:    f_entry = 16'h9AE0;
      3'd3:    f_entry = 16'h9C30;
      3'd4:    f_entry = 16'h9D61;
      3'd5:    f_entry = 16'hA2A4;
      3'd6:    f_entry = {8'h3C, vic};
      default: f_entry = {8'h3B, (mode[3] ? 8'hC8 : 8'h80)};
    endcase
  endfunction

  assign w_mode_ok = mode_valid & ~mode_code[2];

`ifdef ADV_HPD_REINIT_EN
  logic r_hpd_s1, r_hpd_s2, r_hpd_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hpd_s1 <= 1'b0;
      r_hpd_s2 <= 1'b0;
      r_hpd_d  <= 1'b0;
    end else begin
      r_hpd_s1 <= hpd;
      r_hpd_s2 <= r_hpd_s1;
      r_hpd_d  <= r_hpd_s2;
    end
  end
  assign w_hpd_rise = r_hpd_s2 & ~r_hpd_d;
`else
  logic w_unused_hpd;
  assign w_unused_hpd = hpd;
  assign w_hpd_rise   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_PWRUP;
      r_cnt            <= '0;
      r_idx            <= 3'd0;
      r_retry          <= '0;
      r_cur_mode       <= 4'd0;
      r_snap           <= 4'd0;
      r_mode_pending   <= 1'b0;
      r_reinit_pending <= 1'b0;
      r_req            <= 1'b0;
      r_addr           <= 8'h00;
      r_data           <= 8'h00;
      r_busy           <= 1'b1;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_PWRUP: begin
          if (r_cnt == PD_LAST) begin
            r_idx   <= 3'd0;
            r_state <= S_REQ;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (r_reinit_pending || r_mode_pending) begin
            r_snap           <= r_cur_mode;
            r_idx            <= r_reinit_pending ? 3'd0 : 3'd6;
            r_reinit_pending <= 1'b0;
            r_mode_pending   <= 1'b0;
            r_busy           <= 1'b1;
            r_state          <= S_REQ;
          end
        end
        S_REQ: begin
          {r_addr, r_data} <= f_entry(r_idx, r_snap);
          r_req            <= 1'b1;
          r_state          <= S_WAIT;
        end
        S_WAIT: begin
          // An error outranks a simultaneous ack.
          if (i2c_err) begin
            r_req <= 1'b0;
            if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + RW'(1);
              r_state <= S_REQ;
            end else begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FAIL;
            end
          end else if (i2c_ack) begin
            r_req   <= 1'b0;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          r_retry <= '0;
          if (r_idx == 3'd7) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_req  <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
      // New requests are latched after the IDLE clear so they are never lost.
      if (w_mode_ok) begin
        r_cur_mode     <= mode_code;
        r_mode_pending <= 1'b1;
      end
      if (w_hpd_rise && (r_state != S_PWRUP) && (r_state != S_FAIL))
        r_reinit_pending <= 1'b1;
    end
  end

  assign i2c_req   = r_req;
  assign i2c_dev   = DEV_ADDR;
  assign i2c_addr  = r_addr;
  assign i2c_data  = r_data;
  assign busy      = r_busy;
  assign cfg_done  = r_done;
  assign cfg_error = r_error;
endmodule

// File: tb/tb_adv7513_cfg_sequencer.sv
// Scoreboard bench for adv7513_cfg_sequencer: expected writes are queued at stimulus time and popped on each request.
module tb_adv7513_cfg_sequencer;
  localparam int PD = 10;
  localparam int MR = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] mode_code = 4'd0;
  logic       mode_valid = 1'b0;
  logic       hpd = 1'b0;
  logic       i2c_req;
  logic [7:0] i2c_dev, i2c_addr, i2c_data;
  logic       i2c_ack = 1'b0;
  logic       i2c_err = 1'b0;
  logic       busy, cfg_done, cfg_error;

  adv7513_cfg_sequencer #(.POWERUP_DELAY(PD), .MAX_RETRY(MR), .DEV_ADDR(8'h72)) dut (
    .clock(clock), .reset(reset), .mode_code(mode_code), .mode_valid(mode_valid), .hpd(hpd),
    .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_addr(i2c_addr), .i2c_data(i2c_data),
    .i2c_ack(i2c_ack), .i2c_err(i2c_err), .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          exp_done = 0;
  int          act_done = 0;
  int          nreq = 0;
  int          cyc = 0;
  int          first_req_cyc = -1;
  logic [7:0]  err_addr = 8'h00;
  int          err_left = 0;
  int          m_err_left = 0;
  int          ack_dly = 3;
  bit          resp_both = 1'b0;
  bit          spur = 1'b0;
  logic [3:0]  model_mode = 4'd0;

  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference tables written straight from the register map.
  function automatic logic [15:0] common_w(input int i);
    logic [15:0] t[6] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4};
    return t[i];
  endfunction

  function automatic logic [15:0] mode_w(input int k, input logic [3:0] m);
    logic [7:0] vic[4] = '{8'h10, 8'h00, 8'h03, 8'h01};
    if (k == 0) return {8'h3C, vic[m[1:0]]};
    return {8'h3B, (m[3] ? 8'hC8 : 8'h80)};
  endfunction

  task automatic push_w(input logic [15:0] w);
    int n = 1;
    if (w[15:8] == err_addr) begin
      n += m_err_left;
      m_err_left = 0;
    end
    repeat (n) exp_q.push_back(w);
  endtask

  task automatic push_mode(input logic [3:0] m);
    push_w(mode_w(0, m));
    push_w(mode_w(1, m));
    exp_done++;
  endtask

  task automatic push_full(input logic [3:0] m);
    for (int i = 0; i < 6; i++) push_w(common_w(i));
    push_mode(m);
  endtask

  // Monitor: scoreboard pops on every new request, tracks cfg_done.
  initial begin
    logic        prev_req = 1'b0;
    logic        prev_busy = 1'b1;
    logic [15:0] held = 16'h0;
    forever begin
      @(negedge clock);
      if (i2c_req && !prev_req) begin
        nreq++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        chk("dev", {24'h0, i2c_dev}, 32'h72);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got %02h<=%02h, expected no request", i2c_addr, i2c_data);
          held = {i2c_addr, i2c_data};
        end else begin
          held = exp_q.pop_front();
          chk("write", {16'h0, i2c_addr, i2c_data}, {16'h0, held});
        end
      end else if (i2c_req) begin
        chk("hold", {16'h0, i2c_addr, i2c_data}, {16'h0, held});
      end
      if (cfg_done) begin
        act_done++;
        chk("done_busy", {31'h0, busy}, 32'h0);
        chk("done_fall", {31'h0, prev_busy}, 32'h1);
      end
      prev_req  = i2c_req;
      prev_busy = busy;
    end
  end

  // I2C master model: answers each request after ack_dly cycles, injecting planned errors.
  initial begin
    int wcnt = 0;
    forever begin
      @(negedge clock);
      i2c_ack = 1'b0;
      i2c_err = 1'b0;
      if (!i2c_req) begin
        wcnt = 0;
        if (spur) begin
          i2c_ack = 1'b1;
          i2c_err = 1'($urandom_range(0, 1));
        end
      end else begin
        wcnt++;
        if (wcnt == ack_dly) begin
          if (i2c_addr == err_addr && err_left > 0) begin
            i2c_err = 1'b1;
            i2c_ack = resp_both;
            err_left--;
          end else begin
            i2c_ack = 1'b1;
          end
        end
      end
    end
  end

  task automatic send_mode(input logic [3:0] c);
    @(negedge clock);
    mode_code  = c;
    mode_valid = 1'b1;
    @(negedge clock);
    mode_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_req", {31'h0, i2c_req}, 32'h0);
    chk("rst_addr", {24'h0, i2c_addr}, 32'h0);
    chk("rst_data", {24'h0, i2c_data}, 32'h0);
    chk("rst_done", {31'h0, cfg_done}, 32'h0);
    chk("rst_error", {31'h0, cfg_error}, 32'h0);
    model_mode = 4'd0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || act_done != exp_done || busy) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: pending=%0d done=%0d, expected done=%0d", name, exp_q.size(), act_done, exp_done);
      exp_q.delete();
      act_done = exp_done;
    end
    repeat (6) @(negedge clock);
    chk({name, "_done"}, act_done, exp_done);
    chk({name, "_busy"}, {31'h0, busy}, 32'h0);
    chk({name, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!i2c_req && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_req_timeout: got no request, expected one", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [3:0] c, c2, last;
    bit mid_valid;
    // Reset state and power-up sequence
    do_reset();
    push_full(4'd0);
    reset = 1'b0;
    wait_idle("init");
    chk("first_req_cycle", first_req_cyc, PD + 1);

    // Mode A from idle: two writes only
    push_mode(4'hA);
    send_mode(4'hA);
    model_mode = 4'hA;
    wait_idle("modeA");

    // Invalid codes and stray acks change nothing
    base = nreq;
    spur = 1'b1;
    send_mode(4'h5);
    send_mode(4'h7);
    for (int i = 0; i < 4; i++) send_mode(4'h4 | 4'($urandom_range(0, 1) << 3) | 4'($urandom_range(0, 3)));
    repeat (10) @(negedge clock);
    spur = 1'b0;
    repeat (3) @(negedge clock);
    chk("invalid_busy", {31'h0, busy}, 32'h0);
    chk("invalid_nreq", nreq, base);

    // Reset in the middle of a write
    exp_q.push_back(16'h3C03);
    send_mode(4'd2);
    wait_req("midreset");
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_req", {31'h0, i2c_req}, 32'h0);
    chk("midreset_busy", {31'h0, busy}, 32'h1);
    do_reset();

    // Mode changes during the common table: one extra pass with the last code
    push_full(4'd0);
    base = nreq;
    reset = 1'b0;
    begin
      int n = 0;
      while (nreq < base + 2 && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    send_mode(4'd1);
    send_mode(4'd3);
    push_mode(4'd3);
    model_mode = 4'd3;
    wait_idle("midseq");

    // Three errors on 9A (with ack asserted alongside), then success
    do_reset();
    err_addr = 8'h9A; err_left = 3; m_err_left = 3; resp_both = 1'b1;
    push_full(4'd0);
    reset = 1'b0;
    wait_idle("retry");
    chk("retry_error", {31'h0, cfg_error}, 32'h0);

    // Four errors on 98: retries exhausted
    do_reset();
    err_addr = 8'h98; err_left = 4; m_err_left = 0; resp_both = 1'b0;
    exp_q.push_back(16'h4110);
    repeat (4) exp_q.push_back(16'h9803);
    reset = 1'b0;
    begin
      int n = 0;
      while (!cfg_error && n < 300) begin
        @(negedge clock);
        n++;
      end
    end
    repeat (10) @(negedge clock);
    send_mode(4'd1);
    repeat (20) @(negedge clock);
    chk("fail_error", {31'h0, cfg_error}, 32'h1);
    chk("fail_busy", {31'h0, busy}, 32'h0);
    chk("fail_req", {31'h0, i2c_req}, 32'h0);
    chk("fail_queue", exp_q.size(), 0);
    chk("fail_done", act_done, exp_done);
    err_addr = 8'h00; err_left = 0;
    do_reset();

    // Randomised mode traffic with random latency and error injection
    push_full(4'd0);
    reset = 1'b0;
    wait_idle("rand_init");
    for (int it = 0; it < 25; it++) begin
      ack_dly = $urandom_range(1, 5);
      resp_both = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        err_addr = ($urandom_range(0, 1) == 1) ? 8'h3C : 8'h3B;
        err_left = $urandom_range(0, MR);
        m_err_left = err_left;
      end else begin
        err_addr = 8'h00; err_left = 0; m_err_left = 0;
      end
      c = 4'($urandom_range(0, 15));
      if (!c[2]) begin
        push_mode(c);
        model_mode = c;
        send_mode(c);
        if ($urandom_range(0, 1) == 1) begin
          wait_req("rand_mid");
          c2 = 4'($urandom_range(0, 15));
          last = 4'($urandom_range(0, 15));
          mid_valid = !c2[2] || !last[2];
          if (!last[2]) c2 = last;
          send_mode(c2);
          send_mode(last);
          if (mid_valid) begin
            push_mode(c2);
            model_mode = c2;
          end
        end
        wait_idle("rand");
      end else begin
        base = nreq;
        send_mode(c);
        repeat (8) @(negedge clock);
        chk("rand_invalid_nreq", nreq, base);
        chk("rand_invalid_busy", {31'h0, busy}, 32'h0);
      end
    end
    err_addr = 8'h00; err_left = 0; m_err_left = 0; resp_both = 1'b0; ack_dly = 3;

`ifdef ADV_HPD_REINIT_EN
    // hpd edge while idle: full sequence with the current mode
    push_full(model_mode);
    @(negedge clock);
    hpd = 1'b1;
    wait_idle("hpd");
    hpd = 1'b0;
    // hpd edge during power-up is ignored
    do_reset();
    push_full(4'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    hpd = 1'b1;
    wait_idle("hpd_pwrup");
    hpd = 1'b0;
    repeat (5) @(negedge clock);
`else
    base = nreq;
    @(negedge clock);
    hpd = 1'b1;
    repeat (20) @(negedge clock);
    chk("hpd_ignored_nreq", nreq, base);
    chk("hpd_ignored_busy", {31'h0, busy}, 32'h0);
    hpd = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adv7513_cfg_sequencer.md
# adv7513_cfg_sequencer

Sequences ADV7513 register writes through the shared I2C master. After reset it waits out the transmitter power-up delay, then writes a fixed common init table followed by the mode-specific registers for the current output mode. Later mode codes (low nibble of the mode byte from the reconfiguration FIFO) rewrite only the mode registers. It sits between the mode decode and the I2C master, and is the only requester on that master.

## Interface
- POWERUP_DELAY, 200000: clock cycles from reset release until the first I2C request.
- MAX_RETRY, 3: retries allowed per register write after an I2C error.
- DEV_ADDR, 8'h72: ADV7513 8-bit I2C write address, driven on i2c_dev.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- mode_code  in  4  requested mode: 0=1080P, 1=960P, 2=480P, 3=VGA, 8/9/A/B = 240p variants of the same four.
- mode_valid  in  1  one-cycle strobe qualifying mode_code.
- hpd  in  1  hot-plug detect level from the ADV7513 interrupt logic.
- i2c_req  out  1  write request to the I2C master.
- i2c_dev  out  8  device address; constant DEV_ADDR.
- i2c_addr  out  8  register address.
- i2c_data  out  8  register data.
- i2c_ack  in  1  one-cycle pulse: the write completed.
- i2c_err  in  1  one-cycle pulse: the write failed (NACK).
- busy  out  1  high while a sequence is in progress.
- cfg_done  out  1  one-cycle pulse when a sequence completes.
- cfg_error  out  1  sticky; set when retries are exhausted, cleared only by reset.

## Operation
- Common table (index 0-5), written in this order: 41<=10, 98<=03, 9A<=E0, 9C<=30, 9D<=61, A2<=A4.
- Mode table (2 writes):
  - 3C<=VIC, where VIC is 10/00/03/01 for mode[1:0] = 0/1/2/3.
  - 3B<=80 when mode[3]=0; 3B<=C8 when mode[3]=1.
- Valid codes are 0-3 and 8-B. mode_valid with any other code is ignored and changes no state. The initial mode is 0 (1080P).
- States:
  - PWRUP: counts POWERUP_DELAY cycles, then goes to REQ at common index 0.
  - IDLE: waits for a pending mode or a re-init request.
  - REQ: asserts i2c_req with the addr/data of the current entry, then goes to WAIT.
  - WAIT: on i2c_ack goes to NEXT. On i2c_err, if retry_cnt < MAX_RETRY, increments retry_cnt and goes to REQ. Otherwise sets cfg_error and goes to FAIL.
  - NEXT: clears retry_cnt and advances the index. The common table continues into the mode table. After the last mode entry it pulses cfg_done and goes to IDLE.
  - FAIL: terminal until reset. busy=0, i2c_req=0.
- Mode handling:
  - A valid mode_valid in any state latches cur_mode and sets mode_pending.
  - Leaving IDLE clears mode_pending and starts the mode table (index 6). The mode table always uses cur_mode as sampled at that moment.
  - A mode change that arrives during a sequence is serviced by one extra mode-table pass after the current sequence completes. Only the last code received is applied.
- Reset values:
  - busy=1 (PWRUP), i2c_req=0, i2c_addr=00, i2c_data=00, cfg_done=0, cfg_error=0.
  - cur_mode=0, mode_pending=0, retry_cnt=0.

## Timing
- i2c_req rises in the cycle after entering REQ.
- While i2c_req is high, it stays high and i2c_addr/i2c_data stay stable until the cycle after i2c_ack or i2c_err is seen.
- i2c_req drops for at least one cycle between writes, including retries.
- i2c_ack/i2c_err arriving while i2c_req=0 are ignored.
- If i2c_ack and i2c_err arrive together, i2c_err wins.
- cfg_done pulses in the same cycle busy falls.
- A re-init request or mode_valid arriving in the same cycle as sequence completion is serviced next: busy returns high in the following cycle.
- Reset asserted mid-write drops i2c_req next cycle and restarts PWRUP. The I2C master is reset by the same signal.

## Configuration
- ADV_HPD_REINIT_EN defined:
  - hpd is synchronised with 2 flops.
  - A rising edge sets reinit_pending, which starts a full sequence (common + mode tables) from IDLE.
  - An edge during a sequence is serviced after that sequence completes.
  - Ignored in PWRUP and FAIL.
- Not defined: hpd is unused. Only reset produces a full sequence.

## Test plan
- Reset, POWERUP_DELAY=10, ack each write 3 cycles after req:
  - first i2c_req at cycle 11 after reset release, addr 41 data 10.
  - 8 writes in table order, ending 3C<=10, 3B<=80.
  - cfg_done pulses once, busy=0.
- From idle, mode_code=A with mode_valid: exactly 2 writes, 3C<=03 then 3B<=C8, then cfg_done.
- mode_valid with code 5, then code 7: no i2c_req, busy stays 0.
- During the common table, send mode 1 then mode 3: after the 8-write sequence, one extra pass writes 3C<=01 and 3B<=80.
- i2c_err on the write to 9A, three times, then ack: 4 requests to 9A with identical data, then the sequence continues.
- With MAX_RETRY=3, four errors on 98: cfg_error=1, FAIL, no further i2c_req.
- With ADV_HPD_REINIT_EN: an hpd 0->1 edge while idle produces the full 8-write sequence using the current mode.
